// File: rtl/imem_prefetch_pkg.sv
// rtl/imem_prefetch_pkg.sv - shared CPU constants and prefetch FSM encoding
package imem_prefetch_pkg;

  localparam logic [4:0]  OP_HALT  = 5'b00001;
  localparam logic [15:0] NOP_WORD = 16'h0000;
  localparam int          OPC_MSB  = 15;
  localparam int          OPC_LSB  = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } pf_state_t;

  function automatic logic is_halt(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/imem_prefetch_fifo.sv
// rtl/imem_prefetch_fifo.sv - prefetch queue storage with push/pop/flush
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign head_data = mem[rd_ptr];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Pointer/count bookkeeping; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/imem_prefetch.sv
// rtl/imem_prefetch.sv - instruction prefetch FSM feeding a small queue
module imem_prefetch
  import imem_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  input  logic          i_take,
  output logic [DW-1:0] i_datain,
  output logic          i_valid,
  output logic [AW-1:0] i_pc,
  output logic          halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t        state;
  pf_state_t        state_n;
  logic [AW-1:0]    fetch_pc;
  logic [AW-1:0]    pc_n;
  logic [AW-1:0]    req_addr;
  logic             drop_pending;
  logic             drop_n;
  logic             issue;
  logic             hold;
  logic             push;
  logic             pop;
  logic             flush;
  logic [AW+DW-1:0] head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  // A new request goes out only when there is room for its data; an
  // outstanding request (normal or one being dropped) keeps mem_req high
  // with the address that was originally issued.
  assign issue    = (state == ST_FETCH) && !drop_pending && (count < CW'(DEPTH));
  assign hold     = (state == ST_WAIT) || drop_pending;
  assign mem_req  = issue || hold;
  assign mem_addr = hold ? req_addr : (issue ? fetch_pc : '0);

  assign i_valid  = !empty;
  assign i_datain = empty ? DW'(NOP_WORD) : head[DW-1:0];
  assign i_pc     = empty ? '0 : head[AW+DW-1:DW];
  assign halted   = (state == ST_HALTED);

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({fetch_pc, mem_rdata}),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // State, fetch pointer, drop flag and the address of the request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      fetch_pc     <= '0;
      drop_pending <= 1'b0;
      req_addr     <= '0;
    end else begin
      state        <= state_n;
      fetch_pc     <= pc_n;
      drop_pending <= drop_n;
      if (issue) begin
        req_addr <= fetch_pc;
      end
    end
  end

  // Next-state and queue control; redirect overrides take, ack and start.
  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    drop_n  = drop_pending;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    if (redirect && (state != ST_IDLE)) begin
      flush   = 1'b1;
      pc_n    = redirect_addr;
      state_n = ST_FETCH;
      // The memory still owes an ack for any request that has not completed
      // this cycle; that ack must be thrown away.
      drop_n  = issue || (hold && !mem_ack);
    end else begin
      pop = i_take && !empty;
      if (drop_pending && mem_ack) begin
        drop_n = 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc_n    = start_addr;
            state_n = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            state_n = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            push    = !full;
            pc_n    = fetch_pc + AW'(1);
            state_n = is_halt(mem_rdata[15:0]) ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HALTED: begin
          // A restart from HALTED begins a fresh program, so leftovers go.
          if (start) begin
            flush   = 1'b1;
            pop     = 1'b0;
            pc_n    = start_addr;
            state_n = ST_FETCH;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_prefetch.sv
// tb/tb_imem_prefetch.sv - scoreboard bench for imem_prefetch
module tb_imem_prefetch;

  logic        clk = 1'b0;
  logic        rst_n, start, redirect, mem_req, mem_ack, i_take, i_valid, halted;
  logic [7:0]  start_addr, redirect_addr, mem_addr, i_pc;
  logic [15:0] mem_rdata, i_datain;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] data;
  } ent_t;

  ent_t        exp_q[$];
  logic [7:0]  addr_log[$];
  logic [15:0] img[256];
  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  bit          lat_rand = 1'b0;
  bit          inject_ack = 1'b0;
  bit          busy = 1'b0;
  int          m_cnt = 0;
  logic [7:0]  m_addr = '0;

  always #5 clk = ~clk;

  imem_prefetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .i_take        (i_take),
    .i_datain      (i_datain),
    .i_valid       (i_valid),
    .i_pc          (i_pc),
    .halted        (halted)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: the CPU must see consecutive addresses from a, each with the
  // memory word at that address, ending with (and including) the first HALT.
  task automatic build(input logic [7:0] a);
    logic [7:0] pc;
    ent_t e;
    pc = a;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      e.pc   = pc;
      e.data = img[pc];
      exp_q.push_back(e);
      if (img[pc][15:11] == 5'b00001) break;
      pc = pc + 8'd1;
    end
  endtask

  // Memory model: accepts a request, acks after a latency of 1..3 cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && !busy && mem_req === 1'b1 && !mem_ack) begin
        busy   = 1'b1;
        m_addr = mem_addr;
        m_cnt  = lat_rand ? int'($urandom_range(1, 3)) : lat;
        addr_log.push_back(mem_addr);
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst_n !== 1'b1) busy = 1'b0;
      if (busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = img[m_addr];
          busy      = 1'b0;
        end
      end
      if (inject_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
      end
    end
  end

  // Monitor: every consumed head must match the next reference entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (i_valid) begin
          if (i_take && !redirect && !start) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_pop", {24'd0, i_pc}, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("head_pc", {24'd0, i_pc}, {24'd0, e.pc});
              chk("head_data", {16'd0, i_datain}, {16'd0, e.data});
            end
          end
        end else begin
          chk("nop_when_empty", {16'd0, i_datain}, 32'd0);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [7:0]  r;
    bit          found;
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; i_take = 1'b0;
    start_addr = '0; redirect_addr = '0;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'b00001) w[11] = 1'b0;
      img[i] = w;
    end
    img[5] = 16'h0800;

    // Reset values
    repeat (3) step();
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 0);
    chk("rst_i_valid", {31'd0, i_valid}, 0);
    chk("rst_i_datain", {16'd0, i_datain}, 0);
    chk("rst_i_pc", {24'd0, i_pc}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    rst_n = 1'b1;
    step();

    // Start at 0x10, no takes: four fills then mem_req drops
    addr_log.delete();
    build(8'h10);
    start_addr = 8'h10; start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    chk("fill_req_dropped", {31'd0, mem_req}, 0);
    chk("fill_head_pc", {24'd0, i_pc}, 32'h10);
    chk("fill_req_count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("fill_addr", {24'd0, addr_log[i]}, 32'h10 + i);

    // Take every cycle from a full queue
    i_take = 1'b1;
    repeat (6) begin
      chk("stream_valid", {31'd0, i_valid}, 1);
      step();
    end
    i_take = 1'b0;

    // Redirect while waiting on 0x13 with 2-cycle latency
    lat = 2;
    build(8'h10);
    redirect_addr = 8'h10; redirect = 1'b1;
    step();
    redirect = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (mem_req && mem_addr == 8'h13) begin found = 1'b1; break; end
      step();
    end
    chk("saw_req_13", {31'd0, found}, 1);
    step();
    build(8'h40);
    addr_log.delete();
    redirect_addr = 8'h40; redirect = 1'b1;
    step();
    redirect = 1'b0;
    chk("flushed_after_redirect", {31'd0, i_valid}, 0);
    repeat (20) step();
    chk("redirect_first_addr", (addr_log.size() > 0) ? {24'd0, addr_log[0]} : 32'hFFFF, 32'h40);

    // HALT fetched at 0x05
    lat = 1;
    build(8'h03);
    addr_log.delete();
    redirect_addr = 8'h03; redirect = 1'b1;
    step();
    redirect = 1'b0;
    repeat (15) step();
    chk("halted_set", {31'd0, halted}, 1);
    chk("halt_last_addr", (addr_log.size() > 0) ? {24'd0, addr_log[$]} : 32'hFFFF, 32'h05);
    for (int k = 0; k < 5; k++) begin
      chk("halt_no_req", {31'd0, mem_req}, 0);
      step();
    end
    i_take = 1'b1;
    repeat (5) step();
    i_take = 1'b0;
    chk("halt_drained_valid", {31'd0, i_valid}, 0);
    chk("halt_drained_nop", {16'd0, i_datain}, 0);
    chk("halt_still_halted", {31'd0, halted}, 1);
    build(8'h00);
    addr_log.delete();
    redirect_addr = 8'h00; redirect = 1'b1;
    step();
    redirect = 1'b0;
    chk("halt_cleared", {31'd0, halted}, 0);
    repeat (4) step();
    chk("resume_addr", (addr_log.size() > 0) ? {24'd0, addr_log[0]} : 32'hFFFF, 32'h00);

    // Address wrap from 0xFE
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    build(8'hFE);
    addr_log.delete();
    start_addr = 8'hFE; start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    chk("wrap_req_count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("wrap_addr", {24'd0, addr_log[i]}, 32'((8'hFE + i) % 256));
    i_take = 1'b1;
    repeat (4) step();
    i_take = 1'b0;

    // Reset in the middle of a wait, then a late ack while idle
    lat = 3;
    i_take = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (mem_req) begin found = 1'b1; break; end
      step();
    end
    i_take = 1'b0;
    chk("saw_req_before_reset", {31'd0, found}, 1);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 0);
    chk("async_mem_addr", {24'd0, mem_addr}, 0);
    chk("async_i_valid", {31'd0, i_valid}, 0);
    chk("async_i_datain", {16'd0, i_datain}, 0);
    chk("async_i_pc", {24'd0, i_pc}, 0);
    chk("async_halted", {31'd0, halted}, 0);
    step();
    step();
    rst_n = 1'b1;
    inject_ack = 1'b1;
    step();
    inject_ack = 1'b0;
    step();
    chk("late_ack_ignored", {31'd0, i_valid}, 0);
    chk("idle_no_req", {31'd0, mem_req}, 0);

    // Randomized run: random latency, takes and redirects, a few HALTs
    for (int i = 0; i < 6; i++)
      img[$urandom_range(0, 255)] = {5'b00001, 11'($urandom)};
    lat_rand = 1'b1;
    r = 8'($urandom);
    build(r);
    start_addr = r; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      i_take = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) begin
        redirect_addr = 8'($urandom);
        build(redirect_addr);
        redirect = 1'b1;
      end
      step();
      redirect = 1'b0;
    end
    i_take = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
